spi_flash_arb: RTL



---
 rtl/spi_arb_pkg.sv | 19 +
 rtl/spi_pin_mux.sv | 34 +++
 rtl/spi_flash_arb.sv | 104 ++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and sizes for the two-master SPI flash arbiter.
package spi_arb_pkg;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned GUARD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [N_REQ-1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_pin_mux.sv
// Stateless one-hot select of the owner's SCK/CSN/MOSI onto the flash pads,
// with an idle (CSN high) default, plus gated MISO fan-out back to the owner.
module spi_pin_mux
  import spi_arb_pkg::*;
(
  input  logic [N_REQ-1:0] gnt,
  input  logic [N_REQ-1:0] req_sck,
  input  logic [N_REQ-1:0] req_csn,
  input  logic [N_REQ-1:0] req_mosi,
  output logic [N_REQ-1:0] req_miso,
  output logic             pad_sck,
  output logic             pad_csn,
  output logic             pad_mosi,
  input  logic             pad_miso
);

  always_comb begin
    pad_sck  = 1'b0;
    pad_csn  = 1'b1;
    pad_mosi = 1'b0;
    if (gnt[0]) begin
      pad_sck  = req_sck[0];
      pad_csn  = req_csn[0];
      pad_mosi = req_mosi[0];
    end else if (gnt[1]) begin
      pad_sck  = req_sck[1];
      pad_csn  = req_csn[1];
      pad_mosi = req_mosi[1];
    end
  end

  assign req_miso = gnt & {N_REQ{pad_miso}};

endmodule

// File: rtl/spi_flash_arb.sv
// Shares one SPI flash port between two masters; ownership changes only with
// CSN high, followed by a CSN-high guard. Define SPI_ARB_RR_EN for round-robin ties.
module spi_flash_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             busy_o,
  output logic             err_o,
  input  logic [N_REQ-1:0] sck_i,
  input  logic [N_REQ-1:0] csn_i,
  input  logic [N_REQ-1:0] mosi_i,
  output logic [N_REQ-1:0] miso_o,
  output logic             sck_o,
  output logic             csn_o,
  output logic             mosi_o,
  input  logic             miso_i
);

  arb_state_e         state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [GUARD_W-1:0] cnt_q;
  logic               err_q;
  logic               win;
  logic               own_idx;
  logic               release_c;
  logic               intrude_c;

`ifdef SPI_ARB_RR_EN
  logic last_q;
  // On a tie the requester that did not win last time gets the grant.
  assign win = req_i[0] ? (req_i[1] ? ~last_q : 1'b0) : 1'b1;
`else
  assign win = ~req_i[0];
`endif

  assign own_idx   = (state_q == ST_OWN1);
  assign release_c = ~req_i[own_idx] & csn_i[own_idx];

  // CSN low from a non-owner while busy, or from anyone not requesting
  // (including an owner that dropped req early).
  assign intrude_c = ((state_q != ST_IDLE) && |(~csn_i & ~gnt_q)) || |(~csn_i & ~req_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef SPI_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      if (intrude_c) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            state_q <= win ? ST_OWN1 : ST_OWN0;
            gnt_q   <= idx_onehot(win);
`ifdef SPI_ARB_RR_EN
            last_q  <= win;
`endif
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (release_c) begin
            gnt_q <= '0;
            if (GUARD_CYCLES == 0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= GUARD_W'(GUARD_CYCLES - 1);
              state_q <= ST_GUARD;
            end
          end
        end
        ST_GUARD: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - GUARD_W'(1);
        end
      endcase
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = (state_q != ST_IDLE);
  assign err_o  = err_q;

  spi_pin_mux u_pin_mux (
    .gnt      (gnt_q),
    .req_sck  (sck_i),
    .req_csn  (csn_i),
    .req_mosi (mosi_i),
    .req_miso (miso_o),
    .pad_sck  (sck_o),
    .pad_csn  (csn_o),
    .pad_mosi (mosi_o),
    .pad_miso (miso_i)
  );

endmodule
